// File: rtl/sw_debouncer.sv
// Switch debouncer: 2-flop synchronizer, qualification FSM and registered select with edge pulses.
// Latency: a steady sw change reaches sel DEBOUNCE_CYCLES+3 rising edges after it is first sampled.
// Backpressure: none; free-running, sw is sampled every cycle and outputs are never stalled.
//
// Ports:
//   clk      - system clock, all state updates on its rising edge
//   rst      - synchronous active-low reset
//   sw       - raw asynchronous switch / push-button level
//   sel      - clean registered select (level, or toggle per press when TOGGLE_MODE=1)
//   sel_rise - one-cycle pulse coincident with sel going 0->1
//   sel_fall - one-cycle pulse coincident with sel going 1->0
//   busy     - high while a candidate level change is being qualified
module sw_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit TOGGLE_MODE     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    output logic sel,
    output logic sel_rise,
    output logic sel_fall,
    output logic busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t        state;
    logic          sync1;
    logic          sw_s;
    logic          db;
    logic          db_d;
    logic [CW-1:0] cnt;
    logic          sel_nxt;

    // db_d delays db by one cycle so both modes update sel on the same edge:
    // level mode copies db, toggle mode flips on the cycle after db rose.
    always_comb begin
        sel_nxt = db;
        if (TOGGLE_MODE) begin
            sel_nxt = sel ^ (db & ~db_d);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1    <= 1'b0;
            sw_s     <= 1'b0;
            db       <= 1'b0;
            db_d     <= 1'b0;
            cnt      <= '0;
            state    <= STABLE;
            busy     <= 1'b0;
            sel      <= 1'b0;
            sel_rise <= 1'b0;
            sel_fall <= 1'b0;
        end else begin
            sync1    <= sw;
            sw_s     <= sync1;
            db_d     <= db;
            sel      <= sel_nxt;
            sel_rise <= sel_nxt & ~sel;
            sel_fall <= ~sel_nxt & sel;

            case (state)
                STABLE: begin
                    cnt <= '0;
                    if (sw_s != db) begin
                        state <= PENDING;
                        busy  <= 1'b1;
                    end
                end
                PENDING: begin
                    if (sw_s == db) begin
                        // Candidate level vanished before qualifying: drop it silently.
                        state <= STABLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        db    <= sw_s;
                        state <= STABLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= STABLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
